// File: rtl/dvs_ramp_sequencer.sv
// ---------------------------------------------------------------------------
// dvs_ramp_sequencer
//
// Walks the 1.8 V buck regulator from its current DVS code to a requested
// target code, one code per write. After each write it waits for the
// regulator's dvs_done, ignoring the first two cycles after the strobe. It
// then holds for a settle interval before the next step. A regulator timeout,
// or an over/under-voltage flag high on two consecutive cycles, parks the
// sequencer in a sticky FAULT state. Only dropping en, or reset, leaves FAULT.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : synchronous active-high reset
//   en         : regulator enable (level); low aborts to IDLE
//   req_valid  : target request valid
//   req_code   : requested target DVS code
//   req_ready  : request accept (IDLE and enabled), combinational
//   data       : DVS code driven to the regulator (registered)
//   wrb        : active-low write strobe to the regulator (registered)
//   dvs_done   : step-complete flag from the regulator
//   ov_dig     : over-voltage flag from the monitor
//   uv_dig     : under-voltage flag from the monitor
//   cur_code   : last code acknowledged by the regulator
//   busy       : high in every state except IDLE
//   done       : one-cycle pulse when the target is reached
//   fault      : high while in FAULT
// ---------------------------------------------------------------------------
module dvs_ramp_sequencer #(
   parameter logic [3:0] RESET_CODE   = 4'd0,
   parameter int         STEP_WAIT    = 4,
   parameter int         DONE_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       req_valid,
   input  logic [3:0] req_code,
   output logic       req_ready,
   output logic [3:0] data,
   output logic       wrb,
   input  logic       dvs_done,
   input  logic       ov_dig,
   input  logic       uv_dig,
   output logic [3:0] cur_code,
   output logic       busy,
   output logic       done,
   output logic       fault
);

   // Cycles after the write strobe during which dvs_done is not trusted.
   localparam int BLANK_CYCLES = 2;

   // The WAIT_DONE counter runs through the blanking window plus the
   // timeout window, so it must reach BLANK_CYCLES + DONE_TIMEOUT - 1.
   localparam int WAIT_MAX = BLANK_CYCLES + DONE_TIMEOUT;
   localparam int CNT_MAX  = (WAIT_MAX > STEP_WAIT) ? WAIT_MAX : STEP_WAIT;
   localparam int CNT_W    = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] BLANK_END    = CNT_W'(BLANK_CYCLES);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(WAIT_MAX - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(STEP_WAIT - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WRITE     = 3'd1,
      ST_WAIT_DONE = 3'd2,
      ST_SETTLE    = 3'd3,
      ST_FAULT     = 3'd4
   } state_t;

   state_t           state_r;
   logic [3:0]       data_r;
   logic             wrb_r;
   logic [3:0]       cur_code_r;
   logic [3:0]       target_r;
   logic [3:0]       next_r;
   logic [CNT_W-1:0] cnt_r;
   logic             flt_prev_r;
   logic             done_r;

   logic             flag_s;
   logic             flt_trip_s;

   // One code toward the target. Saturates at both ends so a code never
   // wraps, even though a differing target already rules that out.
   function automatic logic [3:0] step_toward(input logic [3:0] cur,
                                              input logic [3:0] tgt);
      logic [3:0] res;
      res = cur;
      if ((tgt > cur) && (cur != 4'd15)) begin
         res = cur + 4'd1;
      end else if ((tgt < cur) && (cur != 4'd0)) begin
         res = cur - 4'd1;
      end else begin
         res = cur;
      end
      return res;
   endfunction

   // Either monitor flag counts; a trip needs the flag on two cycles in a row.
   assign flag_s     = ov_dig | uv_dig;
   assign flt_trip_s = flag_s & flt_prev_r;

   assign req_ready = (state_r == ST_IDLE) & en;
   assign data      = data_r;
   assign wrb       = wrb_r;
   assign cur_code  = cur_code_r;
   assign done      = done_r;
   assign busy      = (state_r != ST_IDLE);
   assign fault     = (state_r == ST_FAULT);

   // Sequencer state machine with all registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         data_r     <= RESET_CODE;
         wrb_r      <= 1'b1;
         cur_code_r <= RESET_CODE;
         target_r   <= RESET_CODE;
         next_r     <= RESET_CODE;
         cnt_r      <= CNT_ZERO;
         flt_prev_r <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         done_r <= 1'b0;
         if (!en) begin
            // Abort: data and cur_code keep their values, no done pulse.
            state_r    <= ST_IDLE;
            wrb_r      <= 1'b1;
            cnt_r      <= CNT_ZERO;
            flt_prev_r <= 1'b0;
         end else begin
            case (state_r)
               ST_IDLE: begin
                  wrb_r      <= 1'b1;
                  flt_prev_r <= 1'b0;
                  if (req_valid) begin
                     target_r <= req_code;
                     if (req_code == cur_code_r) begin
                        done_r <= 1'b1;
                     end else begin
                        next_r  <= step_toward(cur_code_r, req_code);
                        data_r  <= step_toward(cur_code_r, req_code);
                        wrb_r   <= 1'b0;
                        state_r <= ST_WRITE;
                     end
                  end
               end

               ST_WRITE: begin
                  wrb_r      <= 1'b1;
                  cnt_r      <= CNT_ZERO;
                  flt_prev_r <= 1'b0;
                  state_r    <= ST_WAIT_DONE;
               end

               ST_WAIT_DONE: begin
                  flt_prev_r <= flag_s;
                  // A voltage fault outranks dvs_done in the same cycle.
                  if (flt_trip_s) begin
                     flt_prev_r <= 1'b0;
                     state_r    <= ST_FAULT;
                  end else if (cnt_r < BLANK_END) begin
                     cnt_r <= cnt_r + CNT_ONE;
                  end else if (dvs_done) begin
                     cur_code_r <= next_r;
                     cnt_r      <= CNT_ZERO;
                     flt_prev_r <= 1'b0;
                     state_r    <= ST_SETTLE;
                  end else if (cnt_r == TIMEOUT_LAST) begin
                     flt_prev_r <= 1'b0;
                     state_r    <= ST_FAULT;
                  end else begin
                     cnt_r <= cnt_r + CNT_ONE;
                  end
               end

               ST_SETTLE: begin
                  flt_prev_r <= flag_s;
                  if (flt_trip_s) begin
                     flt_prev_r <= 1'b0;
                     state_r    <= ST_FAULT;
                  end else if (cnt_r == SETTLE_LAST) begin
                     cnt_r      <= CNT_ZERO;
                     flt_prev_r <= 1'b0;
                     if (cur_code_r != target_r) begin
                        next_r  <= step_toward(cur_code_r, target_r);
                        data_r  <= step_toward(cur_code_r, target_r);
                        wrb_r   <= 1'b0;
                        state_r <= ST_WRITE;
                     end else begin
                        done_r  <= 1'b1;
                        state_r <= ST_IDLE;
                     end
                  end else begin
                     cnt_r <= cnt_r + CNT_ONE;
                  end
               end

               ST_FAULT: begin
                  // Sticky: only en low (handled above) or rst leaves here.
                  wrb_r      <= 1'b1;
                  flt_prev_r <= 1'b0;
               end

               default: begin
                  wrb_r      <= 1'b1;
                  cnt_r      <= CNT_ZERO;
                  flt_prev_r <= 1'b0;
                  state_r    <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule
